// File: rtl/is2vid_mode_match_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : is2vid_mode_match_ctrl_pkg
//  Purpose  : Shared state encoding and mode-entry record for the
//             image-stream-to-video mode-match controller and timing generator.
//  Revision : 1.0  initial release
// ============================================================================
package is2vid_mode_match_ctrl_pkg;

    // Width of the width/height fields in a mode record.
    localparam int c_mode_dim_bits = 16;

    // One configured video mode. The timing generator's mode table uses the same layout.
    typedef struct packed {
        logic [c_mode_dim_bits-1:0] width;
        logic [c_mode_dim_bits-1:0] height;
        logic                       interlaced;
        logic                       valid;
    } mode_entry_t;

    // Controller state encoding.
    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_search   = 3'd1;
    localparam logic [2:0] c_st_load     = 3'd2;
    localparam logic [2:0] c_st_wait_sof = 3'd3;
    localparam logic [2:0] c_st_locked   = 3'd4;
    localparam logic [2:0] c_st_no_match = 3'd5;

    // An entry matches only when it is enabled and every field agrees with the header.
    function automatic logic entry_matches(
        input mode_entry_t                entry,
        input logic [c_mode_dim_bits-1:0] width,
        input logic [c_mode_dim_bits-1:0] height,
        input logic                       interlaced
    );
        return entry.valid && (entry.width == width) &&
               (entry.height == height) && (entry.interlaced == interlaced);
    endfunction

endpackage
`default_nettype wire

// File: rtl/is2vid_mode_match_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : is2vid_mode_match_ctrl_if
//  Purpose  : Configuration, header, state-machine and generator signals of
//             the mode-match controller. The controller uses the slave modport.
//  Revision : 1.0  initial release
// ============================================================================
interface is2vid_mode_match_ctrl_if #(
    parameter int MODE_BITS = 2,
    parameter int DIM_BITS  = 16
);
    logic                 cfg_wr;
    logic [MODE_BITS-1:0] cfg_addr;
    logic [DIM_BITS-1:0]  cfg_width;
    logic [DIM_BITS-1:0]  cfg_height;
    logic                 cfg_interlaced;
    logic                 cfg_valid;
    logic                 hdr_valid;
    logic [DIM_BITS-1:0]  hdr_width;
    logic [DIM_BITS-1:0]  hdr_height;
    logic                 hdr_interlaced;
    logic                 find_mode;
    logic                 sync_lost;
    logic                 gen_sof;
    logic [MODE_BITS-1:0] gen_mode_sel;
    logic                 gen_mode_load;
    logic                 enable_synced;
    logic                 ap_synched;
    logic                 no_match;

    modport master (
        output cfg_wr, cfg_addr, cfg_width, cfg_height, cfg_interlaced, cfg_valid,
        output hdr_valid, hdr_width, hdr_height, hdr_interlaced,
        output find_mode, sync_lost, gen_sof,
        input  gen_mode_sel, gen_mode_load, enable_synced, ap_synched, no_match
    );

    modport slave (
        input  cfg_wr, cfg_addr, cfg_width, cfg_height, cfg_interlaced, cfg_valid,
        input  hdr_valid, hdr_width, hdr_height, hdr_interlaced,
        input  find_mode, sync_lost, gen_sof,
        output gen_mode_sel, gen_mode_load, enable_synced, ap_synched, no_match
    );
endinterface
`default_nettype wire

// File: rtl/is2vid_mode_bank.sv
`default_nettype none
// ============================================================================
//  Module   : is2vid_mode_bank
//  Purpose  : Register file of configured video modes: one write port and
//             one combinational read port selected by index.
//  Revision : 1.0  initial release
// ============================================================================
module is2vid_mode_bank
    import is2vid_mode_match_ctrl_pkg::*;
#(
    parameter int NUM_MODES = 4,
    parameter int MODE_BITS = 2
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [MODE_BITS-1:0] wr_addr,
    input  mode_entry_t          wr_data,
    input  logic [MODE_BITS-1:0] rd_addr,
    output mode_entry_t          rd_data
);

    mode_entry_t r_entries [NUM_MODES];
    logic        w_wr_in_range;
    logic        w_rd_in_range;

    // Indices past the last entry exist only when NUM_MODES is not a power of two.
    assign w_wr_in_range = (32'(wr_addr) < NUM_MODES);
    assign w_rd_in_range = (32'(rd_addr) < NUM_MODES);

    // Entry storage; reset leaves every entry disabled, out-of-range writes are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_MODES; i++) begin
                r_entries[i] <= '0;
            end
        end else if (wr_en && w_wr_in_range) begin
            r_entries[wr_addr] <= wr_data;
        end
    end

    assign rd_data = w_rd_in_range ? r_entries[rd_addr] : '0;

endmodule
`default_nettype wire

// File: rtl/is2vid_mode_match_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : is2vid_mode_match_ctrl
//  Purpose  : Latches decoded control-packet dimensions, searches the mode
//             bank one entry per cycle on FIND_MODE, loads the matched mode
//             into the timing generator and reports lock to the state machine.
//  Revision : 1.0  initial release
// ============================================================================
module is2vid_mode_match_ctrl
    import is2vid_mode_match_ctrl_pkg::*;
#(
    parameter int NUM_MODES = 4,
    parameter int MODE_BITS = 2,
    parameter int DIM_BITS  = 16
)(
    input  logic                     clk,
    input  logic                     rst,
    is2vid_mode_match_ctrl_if.slave  bus
);

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic [MODE_BITS-1:0] r_idx;
    logic [MODE_BITS-1:0] r_mode_sel;
    logic [DIM_BITS-1:0]  r_hdr_width;
    logic [DIM_BITS-1:0]  r_hdr_height;
    logic                 r_hdr_interlaced;
    logic                 r_hdr_seen;
    logic                 r_running;
    logic                 r_mode_load;
    logic                 r_ap_synched;
    logic                 r_no_match;

    mode_entry_t          w_wr_entry;
    mode_entry_t          w_rd_entry;
    logic                 w_entry_match;
    logic                 w_last_idx;
    logic                 w_fast_path;
    logic                 w_hdr_differs;
    logic                 w_active_write;

    // Pack the configuration bus into a bank record.
    always_comb begin
        w_wr_entry            = '0;
        w_wr_entry.width      = bus.cfg_width;
        w_wr_entry.height     = bus.cfg_height;
        w_wr_entry.interlaced = bus.cfg_interlaced;
        w_wr_entry.valid      = bus.cfg_valid;
    end

    is2vid_mode_bank #(
        .NUM_MODES (NUM_MODES),
        .MODE_BITS (MODE_BITS)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.cfg_wr),
        .wr_addr (bus.cfg_addr),
        .wr_data (w_wr_entry),
        .rd_addr (r_idx),
        .rd_data (w_rd_entry)
    );

    assign w_entry_match  = entry_matches(w_rd_entry, r_hdr_width, r_hdr_height, r_hdr_interlaced);
    assign w_last_idx     = (32'(r_idx) == NUM_MODES - 1);
    // The generator already runs this entry, so no reload is needed.
    assign w_fast_path    = r_running && (r_idx == r_mode_sel);
    assign w_hdr_differs  = (bus.hdr_width != r_hdr_width) || (bus.hdr_height != r_hdr_height) ||
                            (bus.hdr_interlaced != r_hdr_interlaced);
    assign w_active_write = bus.cfg_wr && (bus.cfg_addr == r_mode_sel);

    // Next-state selection; earlier conditions in each state take priority.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (bus.find_mode && r_hdr_seen) w_next_state = c_st_search;
            end
            c_st_search: begin
                if (bus.hdr_valid)      w_next_state = c_st_search;
                else if (w_entry_match) w_next_state = w_fast_path ? c_st_locked : c_st_load;
                else if (w_last_idx)    w_next_state = c_st_no_match;
            end
            c_st_load: begin
                w_next_state = c_st_wait_sof;
            end
            c_st_wait_sof: begin
                // A SOF coinciding with the load strobe predates the new mode.
                if (bus.sync_lost)                     w_next_state = c_st_idle;
                else if (bus.gen_sof && !r_mode_load)  w_next_state = c_st_locked;
            end
            c_st_locked: begin
                if (bus.sync_lost || (bus.hdr_valid && w_hdr_differs) || w_active_write)
                    w_next_state = c_st_idle;
            end
            c_st_no_match: begin
                if (bus.hdr_valid || bus.cfg_wr) w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // Header latch; once a header has been seen a search may start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hdr_width      <= '0;
            r_hdr_height     <= '0;
            r_hdr_interlaced <= 1'b0;
            r_hdr_seen       <= 1'b0;
        end else if (bus.hdr_valid) begin
            r_hdr_width      <= bus.hdr_width;
            r_hdr_height     <= bus.hdr_height;
            r_hdr_interlaced <= bus.hdr_interlaced;
            r_hdr_seen       <= 1'b1;
        end
    end

    // State, search index, generator control and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_idx        <= '0;
            r_mode_sel   <= '0;
            r_running    <= 1'b0;
            r_mode_load  <= 1'b0;
            r_ap_synched <= 1'b0;
            r_no_match   <= 1'b0;
        end else begin
            r_state <= w_next_state;

            case (r_state)
                c_st_idle: r_idx <= '0;
                c_st_search: begin
                    if (bus.hdr_valid)                      r_idx <= '0;
                    else if (!w_entry_match && !w_last_idx) r_idx <= r_idx + 1'b1;
                end
                default: r_idx <= r_idx;
            endcase

            r_mode_load <= (r_state == c_st_load);

            if (r_state == c_st_load) begin
                r_mode_sel <= r_idx;
                r_running  <= 1'b0;
            end else if ((r_state == c_st_wait_sof) && (w_next_state == c_st_locked)) begin
                r_running  <= 1'b1;
            end

            // On the fast path the lock is reported one cycle after entering LOCKED,
            // aligning it with where the load strobe would have appeared.
            r_ap_synched <= (w_next_state == c_st_locked) && (r_state != c_st_search);

            if (w_next_state == c_st_no_match)
                r_no_match <= 1'b1;
            else if ((w_next_state == c_st_search) && (r_state != c_st_search))
                r_no_match <= 1'b0;
        end
    end

    assign bus.gen_mode_sel  = r_mode_sel;
    assign bus.gen_mode_load = r_mode_load;
    assign bus.enable_synced = r_mode_load;
    assign bus.ap_synched    = r_ap_synched;
    assign bus.no_match      = r_no_match;

endmodule
`default_nettype wire

// File: tb/tb_is2vid_mode_match_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_is2vid_mode_match_ctrl
//  Purpose  : Self-checking bench for the mode-match controller; expected
//             outputs come from a behavioural mode-bank model and the
//             cycle offsets of the search/load/lock sequence.
//  Revision : 1.0  initial release
// ============================================================================
module tb_is2vid_mode_match_ctrl;
    localparam int NUM_MODES = 4;
    localparam int MODE_BITS = 2;
    localparam int DIM_BITS  = 16;
    localparam int OW        = MODE_BITS + 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    // Behavioural bank model.
    int m_w [NUM_MODES];
    int m_h [NUM_MODES];
    bit m_i [NUM_MODES];
    bit m_v [NUM_MODES];

    is2vid_mode_match_ctrl_if #(.MODE_BITS(MODE_BITS), .DIM_BITS(DIM_BITS)) bus ();

    is2vid_mode_match_ctrl #(
        .NUM_MODES (NUM_MODES),
        .MODE_BITS (MODE_BITS),
        .DIM_BITS  (DIM_BITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OW-1:0] sample();
        return {bus.gen_mode_sel, bus.gen_mode_load, bus.enable_synced, bus.ap_synched, bus.no_match};
    endfunction

    // Expected output vector: load strobe and enable_synced always coincide.
    function automatic logic [OW-1:0] exp_of(input int sel, input bit ld, input bit ap, input bit nm);
        return {MODE_BITS'(sel), ld, ld, ap, nm};
    endfunction

    function automatic int model_match(input int w, input int h, input bit i);
        for (int j = 0; j < NUM_MODES; j++)
            if (m_v[j] && m_w[j] == w && m_h[j] == h && m_i[j] == i) return j;
        return -1;
    endfunction

    function automatic void model_clear();
        for (int j = 0; j < NUM_MODES; j++) begin
            m_w[j] = 0; m_h[j] = 0; m_i[j] = 1'b0; m_v[j] = 1'b0;
        end
    endfunction

    function automatic int pick_w();
        case ($urandom_range(0, 3))
            0: return 640;
            1: return 720;
            2: return 1280;
            default: return 1920;
        endcase
    endfunction

    function automatic int pick_h();
        case ($urandom_range(0, 3))
            0: return 360;
            1: return 480;
            2: return 720;
            default: return 1080;
        endcase
    endfunction

    task automatic clear_inputs();
        bus.cfg_wr = 1'b0; bus.cfg_addr = '0; bus.cfg_width = '0; bus.cfg_height = '0;
        bus.cfg_interlaced = 1'b0; bus.cfg_valid = 1'b0;
        bus.hdr_valid = 1'b0; bus.hdr_width = '0; bus.hdr_height = '0; bus.hdr_interlaced = 1'b0;
        bus.find_mode = 1'b0; bus.sync_lost = 1'b0; bus.gen_sof = 1'b0;
    endtask

    task automatic cfg_write(input int a, input int w, input int h, input bit i, input bit v);
        bus.cfg_wr = 1'b1; bus.cfg_addr = MODE_BITS'(a);
        bus.cfg_width = DIM_BITS'(w); bus.cfg_height = DIM_BITS'(h);
        bus.cfg_interlaced = i; bus.cfg_valid = v;
        tick();
        bus.cfg_wr = 1'b0;
        if (a < NUM_MODES) begin
            m_w[a] = w; m_h[a] = h; m_i[a] = i; m_v[a] = v;
        end
    endtask

    task automatic hdr_pulse(input int w, input int h, input bit i);
        bus.hdr_valid = 1'b1; bus.hdr_width = DIM_BITS'(w);
        bus.hdr_height = DIM_BITS'(h); bus.hdr_interlaced = i;
        tick();
        bus.hdr_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [OW-1:0] obs;
        clear_inputs();
        model_clear();
        rst = 1'b1;
        repeat (3) tick();
        obs = sample();
        total++;
        if (obs !== exp_of(0, 0, 0, 0)) $display("FAIL reset_values: outputs=%b want %b", obs, exp_of(0, 0, 0, 0));
        else passed++;
        rst = 1'b0;
        // No header seen yet: find_mode must not start a search.
        bus.find_mode = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            tick();
            obs = sample();
            total++;
            if (obs !== exp_of(0, 0, 0, 0)) $display("FAIL no_header_idle n=%0d: outputs=%b want %b", n, obs, exp_of(0, 0, 0, 0));
            else passed++;
        end
        bus.find_mode = 1'b0;
    endtask

    task automatic test_basic_load();
        logic [OW-1:0] obs, expv;
        int k;
        cfg_write(0, 720, 480, 1'b1, 1'b1);
        cfg_write(1, 1280, 720, 1'b0, 1'b1);
        hdr_pulse(1280, 720, 1'b0);
        k = model_match(1280, 720, 1'b0);
        bus.find_mode = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            bus.find_mode = 1'b0;
            bus.gen_sof = (n == 9);
            obs  = sample();
            expv = exp_of((n >= 3 + k) ? k : 0, n == 3 + k, n >= 10, 1'b0);
            total++;
            if (obs !== expv) $display("FAIL basic_load n=%0d: outputs(sel,load,en,ap,nm)=%b want %b", n, obs, expv);
            else passed++;
        end
        bus.gen_sof = 1'b0;
    endtask

    task automatic test_fast_path();
        logic [OW-1:0] obs, expv;
        // Same header again plus find_mode while locked: lock is held.
        bus.find_mode = 1'b1;
        hdr_pulse(1280, 720, 1'b0);
        bus.find_mode = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            obs = sample();
            total++;
            if (obs !== exp_of(1, 0, 1, 0)) $display("FAIL same_hdr_hold n=%0d: outputs=%b want %b", n, obs, exp_of(1, 0, 1, 0));
            else passed++;
            tick();
        end
        // Lose sync while locked.
        bus.sync_lost = 1'b1;
        tick();
        bus.sync_lost = 1'b0;
        obs = sample();
        total++;
        if (obs !== exp_of(1, 0, 0, 0)) $display("FAIL sync_lost_locked: outputs=%b want %b", obs, exp_of(1, 0, 0, 0));
        else passed++;
        // Generator still runs entry 1: relock without a load strobe.
        bus.find_mode = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            tick();
            bus.find_mode = 1'b0;
            obs  = sample();
            expv = exp_of(1, 1'b0, n >= 4, 1'b0);
            total++;
            if (obs !== expv) $display("FAIL fast_path n=%0d: outputs=%b want %b", n, obs, expv);
            else passed++;
        end
    endtask

    task automatic test_no_match();
        logic [OW-1:0] obs, expv;
        hdr_pulse(1920, 1080, 1'b0);
        obs = sample();
        total++;
        if (obs !== exp_of(1, 0, 0, 0)) $display("FAIL new_hdr_unlock: outputs=%b want %b", obs, exp_of(1, 0, 0, 0));
        else passed++;
        bus.find_mode = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            tick();
            bus.find_mode = 1'b0;
            obs  = sample();
            expv = exp_of(1, 1'b0, 1'b0, n >= NUM_MODES + 1);
            total++;
            if (obs !== expv) $display("FAIL no_match n=%0d: outputs=%b want %b", n, obs, expv);
            else passed++;
        end
        cfg_write(3, 1920, 1080, 1'b0, 1'b1);
        bus.find_mode = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            tick();
            bus.find_mode = 1'b0;
            obs  = sample();
            expv = exp_of((n >= 6) ? 3 : 1, n == 6, 1'b0, 1'b0);
            total++;
            if (obs !== expv) $display("FAIL load_entry3 n=%0d: outputs=%b want %b", n, obs, expv);
            else passed++;
        end
    endtask

    task automatic test_sync_lost_wait();
        logic [OW-1:0] obs;
        bus.sync_lost = 1'b1;
        tick();
        bus.sync_lost = 1'b0;
        // A later SOF must not lock: the controller is back in IDLE.
        bus.gen_sof = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            obs = sample();
            total++;
            if (obs !== exp_of(3, 0, 0, 0)) $display("FAIL sync_lost_wait n=%0d: outputs=%b want %b", n, obs, exp_of(3, 0, 0, 0));
            else passed++;
            tick();
            bus.gen_sof = 1'b0;
        end
    endtask

    task automatic test_locked_hdr_cfg();
        logic [OW-1:0] obs, expv;
        int k;
        bus.find_mode = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            tick();
            bus.find_mode = 1'b0;
            bus.gen_sof = (n == 8);
            obs  = sample();
            expv = exp_of(3, n == 6, n >= 9, 1'b0);
            total++;
            if (obs !== expv) $display("FAIL relock_entry3 n=%0d: outputs=%b want %b", n, obs, expv);
            else passed++;
        end
        bus.gen_sof = 1'b0;
        // New header and a write to the active entry in the same cycle.
        bus.hdr_valid = 1'b1; bus.hdr_width = 16'd640; bus.hdr_height = 16'd360; bus.hdr_interlaced = 1'b0;
        cfg_write(3, 640, 360, 1'b0, 1'b1);
        bus.hdr_valid = 1'b0;
        obs = sample();
        total++;
        if (obs !== exp_of(3, 0, 0, 0)) $display("FAIL hdr_cfg_unlock: outputs=%b want %b", obs, exp_of(3, 0, 0, 0));
        else passed++;
        k = model_match(640, 360, 1'b0);
        bus.find_mode = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            tick();
            bus.find_mode = 1'b0;
            obs  = sample();
            expv = exp_of(3, 1'b0, (k >= 0) && (n >= 3 + k), k < 0 && n >= NUM_MODES + 1);
            total++;
            if (obs !== expv) $display("FAIL hdr_cfg_relock n=%0d: outputs=%b want %b", n, obs, expv);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic [OW-1:0] obs, expv;
        int w, h;
        bus.sync_lost = 1'b1;
        tick();
        bus.sync_lost = 1'b0;
        bus.find_mode = 1'b1;
        tick();
        bus.find_mode = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1 obs = sample();
        total++;
        if (obs !== exp_of(0, 0, 0, 0)) $display("FAIL reset_mid_search: outputs=%b want %b", obs, exp_of(0, 0, 0, 0));
        else passed++;
        tick(); tick();
        rst = 1'b0;
        model_clear();
        w = pick_w(); h = pick_h();
        cfg_write(2, w, h, 1'b1, 1'b1);
        hdr_pulse(w, h, 1'b1);
        bus.find_mode = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            tick();
            bus.find_mode = 1'b0;
            obs  = sample();
            expv = exp_of((n >= 5) ? 2 : 0, n == 5, 1'b0, 1'b0);
            total++;
            if (obs !== expv) $display("FAIL pre_reset_load n=%0d: outputs=%b want %b", n, obs, expv);
            else passed++;
        end
        #2 rst = 1'b1;
        #1 obs = sample();
        total++;
        if (obs !== exp_of(0, 0, 0, 0)) $display("FAIL reset_mid_wait_sof: outputs=%b want %b", obs, exp_of(0, 0, 0, 0));
        else passed++;
        tick();
        rst = 1'b0;
        model_clear();
        // Entry 2 was cleared by reset, so the same header finds nothing.
        hdr_pulse(w, h, 1'b1);
        bus.find_mode = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            tick();
            bus.find_mode = 1'b0;
            obs  = sample();
            expv = exp_of(0, 1'b0, 1'b0, n >= NUM_MODES + 1);
            total++;
            if (obs !== expv) $display("FAIL bank_cleared n=%0d: outputs=%b want %b", n, obs, expv);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [OW-1:0] obs, expv;
        int w, h, k, j;
        bit il;
        for (int it = 0; it < 16; it++) begin
            clear_inputs();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            model_clear();
            for (int a = 0; a < NUM_MODES; a++)
                cfg_write(a, pick_w(), pick_h(), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                j = $urandom_range(0, NUM_MODES - 1);
                w = m_w[j]; h = m_h[j]; il = m_i[j];
            end else begin
                w = pick_w(); h = pick_h(); il = 1'($urandom_range(0, 1));
            end
            hdr_pulse(w, h, il);
            k = model_match(w, h, il);
            bus.find_mode = 1'b1;
            for (int n = 1; n <= 14; n++) begin
                tick();
                bus.find_mode = 1'b0;
                // SOF during LOAD is ignored; the later one locks.
                bus.gen_sof = (k >= 0) && ((n == 2 + k) || (n == 6 + k));
                obs = sample();
                if (k >= 0) expv = exp_of((n >= 3 + k) ? k : 0, n == 3 + k, n >= 7 + k, 1'b0);
                else        expv = exp_of(0, 1'b0, 1'b0, n >= NUM_MODES + 1);
                total++;
                if (obs !== expv) $display("FAIL random it=%0d k=%0d n=%0d: outputs=%b want %b", it, k, n, obs, expv);
                else passed++;
            end
            bus.gen_sof = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_fast_path();
        test_no_match();
        test_sync_lost_wait();
        test_locked_hdr_cfg();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
